// File: rtl/tone_meter.sv
// Square-wave period meter: measures high and low phase lengths of sig_in in clk cycles,
// reports each complete period with a one-cycle strobe and flags a silent input.
module tone_meter #(
  parameter int TIMEOUT = 1_000_000,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W-1:0] half_period,
  output logic             valid,
  output logic             symmetric,
  output logic             silent
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic             sync1_reg, s_reg, s_d_reg;
  logic             rise_reg, fall_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hcap_reg, hcap_next;
  logic [CNT_W-1:0] high_next, low_next, half_next;
  logic             valid_next, sym_next, silent_next;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] diff;

  // Synchronizer plus a registered edge detector; the FSM acts one cycle after the edge is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      s_reg     <= 1'b0;
      s_d_reg   <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync1_reg <= sig_in;
      s_reg     <= sync1_reg;
      s_d_reg   <= s_reg;
      rise_reg  <= s_reg & ~s_d_reg;
      fall_reg  <= ~s_reg & s_d_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hcap_reg    <= '0;
      high_cnt    <= '0;
      low_cnt     <= '0;
      half_period <= '0;
      valid       <= 1'b0;
      symmetric   <= 1'b0;
      silent      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hcap_reg    <= hcap_next;
      high_cnt    <= high_next;
      low_cnt     <= low_next;
      half_period <= half_next;
      valid       <= valid_next;
      symmetric   <= sym_next;
      silent      <= silent_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hcap_next   = hcap_reg;
    high_next   = high_cnt;
    low_next    = low_cnt;
    half_next   = half_period;
    valid_next  = 1'b0;
    sym_next    = symmetric;
    silent_next = silent;
    // Full-width sum so a period longer than 2^CNT_W-1 still halves correctly.
    sum  = {1'b0, hcap_reg} + {1'b0, cnt_reg};
    diff = (hcap_reg >= cnt_reg) ? (hcap_reg - cnt_reg) : (cnt_reg - hcap_reg);

    case (state_reg)
      IDLE: begin
        if (rise_reg) begin
          state_next = HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      HIGH: begin
        if (fall_reg) begin
          hcap_next  = cnt_reg;
          cnt_next   = CNT_ONE;
          state_next = LOW;
        end else if (cnt_reg == CNT_LIM) begin
          cnt_next    = CNT_SAT;
          state_next  = IDLE;
          silent_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      LOW: begin
        if (rise_reg) begin
          high_next   = hcap_reg;
          low_next    = cnt_reg;
          half_next   = CNT_W'(sum >> 1);
          sym_next    = (diff <= CNT_ONE);
          valid_next  = 1'b1;
          silent_next = 1'b0;
          cnt_next    = CNT_ONE;
          state_next  = HIGH;
        end else if (cnt_reg == CNT_LIM) begin
          cnt_next    = CNT_SAT;
          state_next  = IDLE;
          silent_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tone_meter.sv
// Bench for tone_meter: two instances (long and short timeout) driven by directed tone patterns,
// checked every cycle against an edge-timestamp model plus hand-computed literal results.
module tb_tone_meter;

  localparam int CNT_W = 32;
  localparam int TO_A  = 1_000_000;
  localparam int TO_B  = 1000;
  localparam int MAX_PRINT = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic sig_a = 1'b0, sig_b = 1'b0;
  logic [CNT_W-1:0] high_a, low_a, half_a, high_b, low_b, half_b;
  logic valid_a, sym_a, silent_a, valid_b, sym_b, silent_b;

  tone_meter #(.TIMEOUT(TO_A), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst_a), .sig_in(sig_a),
    .high_cnt(high_a), .low_cnt(low_a), .half_period(half_a),
    .valid(valid_a), .symmetric(sym_a), .silent(silent_a)
  );

  tone_meter #(.TIMEOUT(TO_B), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst_b), .sig_in(sig_b),
    .high_cnt(high_b), .low_cnt(low_b), .half_period(half_b),
    .valid(valid_b), .symmetric(sym_b), .silent(silent_b)
  );

  int errors = 0;
  int checks = 0;
  int printed = 0;
  int vcnt_a = 0;
  int vcnt_b = 0;

  // Inputs as seen by each posedge, so the model never races the drivers.
  logic smp_rst [2];
  logic smp_sig [2];
  always @(posedge clk) begin
    smp_rst[0] <= rst_a;
    smp_rst[1] <= rst_b;
    smp_sig[0] <= sig_a;
    smp_sig[1] <= sig_b;
  end

  // Model: the input is observed with a fixed pipeline delay; a period is reported at an
  // observed rise when a rise and a fall were timestamped before it with no timeout between.
  bit       m_started [2];
  bit [4:0] m_sh [2];
  bit       m_active [2];
  bit       m_have_fall [2];
  longint   m_t [2], m_tr [2], m_tf [2];
  longint   e_high [2], e_low [2], e_half [2];
  bit       e_sym [2], e_silent [2], e_valid [2];

  task automatic report_fail(input string msg);
    errors++;
    if (printed < MAX_PRINT) $display("FAIL %s", msg);
    printed++;
  endtask

  task automatic model_step(input int i);
    longint to_v, last;
    bit seen, prev;
    to_v = (i == 0) ? longint'(TO_A) : longint'(TO_B);
    m_t[i]++;
    if (smp_rst[i] === 1'b1) begin
      m_started[i] = 1'b1;
      m_sh[i] = '0;
      m_active[i] = 1'b0;
      m_have_fall[i] = 1'b0;
      e_high[i] = 0; e_low[i] = 0; e_half[i] = 0;
      e_sym[i] = 1'b0; e_silent[i] = 1'b1; e_valid[i] = 1'b0;
    end else if (m_started[i]) begin
      m_sh[i] = {m_sh[i][3:0], smp_sig[i] === 1'b1};
      seen = m_sh[i][3];
      prev = m_sh[i][4];
      e_valid[i] = 1'b0;
      last = m_have_fall[i] ? m_tf[i] : m_tr[i];
      if (seen && !prev) begin
        if (m_active[i] && m_have_fall[i]) begin
          e_high[i]   = m_tf[i] - m_tr[i];
          e_low[i]    = m_t[i] - m_tf[i];
          e_half[i]   = (e_high[i] + e_low[i]) / 2;
          e_sym[i]    = (e_high[i] - e_low[i] <= 1) && (e_low[i] - e_high[i] <= 1);
          e_valid[i]  = 1'b1;
          e_silent[i] = 1'b0;
        end
        m_active[i] = 1'b1;
        m_have_fall[i] = 1'b0;
        m_tr[i] = m_t[i];
      end else if (!seen && prev && m_active[i] && !m_have_fall[i]) begin
        m_tf[i] = m_t[i];
        m_have_fall[i] = 1'b1;
      end else if (m_active[i] && (m_t[i] - last == to_v - 1)) begin
        m_active[i] = 1'b0;
        e_silent[i] = 1'b1;
      end
    end
  endtask

  task automatic model_cmp(input int i);
    logic [3*CNT_W+2:0] got, want;
    if (i == 0) got = {high_a, low_a, half_a, valid_a, sym_a, silent_a};
    else        got = {high_b, low_b, half_b, valid_b, sym_b, silent_b};
    want = {CNT_W'(e_high[i]), CNT_W'(e_low[i]), CNT_W'(e_half[i]), e_valid[i], e_sym[i], e_silent[i]};
    checks++;
    if (got !== want)
      report_fail($sformatf("model_cmp inst=%0d t=%0t got h/l/half/v/sym/sil=%0d/%0d/%0d/%b/%b/%b want %0d/%0d/%0d/%b/%b/%b",
                  i, $time, got[3*CNT_W+2:2*CNT_W+3], got[2*CNT_W+2:CNT_W+3], got[CNT_W+2:3],
                  got[2], got[1], got[0], e_high[i], e_low[i], e_half[i], e_valid[i], e_sym[i], e_silent[i]));
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      model_step(i);
      if (m_started[i]) model_cmp(i);
    end
    if (valid_a === 1'b1) vcnt_a++;
    if (valid_b === 1'b1) vcnt_b++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) report_fail($sformatf("%s got=%0d want=%0d", name, act, exp));
    else $display("check %s = %0d ok", name, act);
  endtask

  task automatic hold_a(input logic v, input int n);
    sig_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_b(input logic v, input int n);
    sig_b = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic seq_a();
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("a_rst_high", high_a, 0);
    chk("a_rst_silent", silent_a, 1);
    hold_a(0, 10);
    hold_a(1, 23860);
    hold_a(0, 23860);
    hold_a(1, 10);
    #1;
    chk("a_23860_high", high_a, 23860);
    chk("a_23860_low", low_a, 23860);
    chk("a_23860_half", half_a, 23860);
    chk("a_23860_sym", sym_a, 1);
    chk("a_23860_silent", silent_a, 0);
    chk("a_23860_vcnt", vcnt_a, 1);
    hold_a(1, 21292);
    hold_a(0, 21302);
    hold_a(1, 10);
    #1;
    chk("a_21302_high", high_a, 21302);
    chk("a_21302_low", low_a, 21302);
    chk("a_21302_half", half_a, 21302);
    chk("a_21302_sym", sym_a, 1);
    chk("a_21302_vcnt", vcnt_a, 2);
  endtask

  task automatic seq_b();
    int lat;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("b_rst_low", low_b, 0);
    chk("b_rst_valid", valid_b, 0);
    hold_b(0, 5000);
    #1;
    chk("b_idle_silent", silent_b, 1);
    chk("b_idle_vcnt", vcnt_b, 0);
    chk("b_idle_half", half_b, 0);
    // asymmetric 100/300
    hold_b(1, 100); hold_b(0, 300); hold_b(1, 100); hold_b(0, 300); hold_b(1, 10);
    #1;
    chk("b_asym_high", high_b, 100);
    chk("b_asym_low", low_b, 300);
    chk("b_asym_half", half_b, 200);
    chk("b_asym_sym", sym_b, 0);
    chk("b_asym_vcnt", vcnt_b, 2);
    // 500/500 tone, then stuck high past the timeout
    hold_b(1, 490); hold_b(0, 500); hold_b(1, 10);
    #1;
    chk("b_500_high", high_b, 500);
    chk("b_500_sym", sym_b, 1);
    hold_b(1, 1490);
    #1;
    chk("b_stuck_silent", silent_b, 1);
    chk("b_stuck_high_held", high_b, 500);
    chk("b_stuck_low_held", low_b, 500);
    chk("b_stuck_vcnt", vcnt_b, 3);
    hold_b(0, 500); hold_b(1, 500); hold_b(0, 500);
    #1;
    chk("b_resume_still_silent", silent_b, 1);
    // latency probe: valid on the 4th edge counting the first edge that samples high
    sig_b = 1'b1;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (valid_b === 1'b1 && lat == 0) lat = k;
    end
    @(negedge clk);
    #1;
    chk("b_valid_latency", lat, 4);
    chk("b_resume_silent", silent_b, 0);
    chk("b_resume_low", low_b, 500);
    // 200/200 tone with a mid-low reset
    hold_b(1, 194);
    hold_b(0, 200); hold_b(1, 200); hold_b(0, 200); hold_b(1, 10);
    #1;
    chk("b_200_high", high_b, 200);
    chk("b_200_vcnt", vcnt_b, 6);
    hold_b(1, 190); hold_b(0, 100);
    rst_b = 1'b1;
    hold_b(0, 1);
    rst_b = 1'b0;
    #1;
    chk("b_midrst_high", high_b, 0);
    chk("b_midrst_silent", silent_b, 1);
    hold_b(0, 99); hold_b(1, 200); hold_b(0, 200);
    #1;
    chk("b_midrst_no_valid", vcnt_b, 6);
    chk("b_midrst_still_silent", silent_b, 1);
    hold_b(1, 10);
    #1;
    chk("b_after_rst_high", high_b, 200);
    chk("b_after_rst_low", low_b, 200);
    chk("b_after_rst_silent", silent_b, 0);
    // one-cycle glitch is a legal high phase
    hold_b(1, 190); hold_b(0, 7); hold_b(1, 1); hold_b(0, 7);
    #1;
    chk("b_pre_glitch_low", low_b, 7);
    chk("b_pre_glitch_half", half_b, 103);
    hold_b(1, 5);
    #1;
    chk("b_glitch_high", high_b, 1);
    chk("b_glitch_half", half_b, 4);
    chk("b_glitch_sym", sym_b, 0);
    chk("b_glitch_vcnt", vcnt_b, 9);
    hold_b(0, 20);
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
